// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the conv_core 2x2 valid-mode convolution engine.
package conv_pkg;
  localparam int PIX_W       = 3;
  localparam int MAT_N       = 6;
  localparam int KER_SZ      = 2;
  localparam int TAPS        = KER_SZ * KER_SZ;
  localparam int OUT_W       = 8;
  localparam int RES_PER_KER = (MAT_N - 1) * (MAT_N - 1);
  localparam int RES_TOTAL   = MAT_N * RES_PER_KER;
  localparam int CNT_W       = 3;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAT_N - 1);
  localparam logic [CNT_W-1:0] LAST_K    = CNT_W'(MAT_N - 1);
  localparam logic [CNT_W-1:0] LAST_RC   = CNT_W'(MAT_N - KER_SZ);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_CALC = 1'b1
  } state_e;
endpackage

// File: rtl/conv_core_if.sv
// Beat input, FIFO write and status signals between the synchronizer/FIFO side and conv_core.
interface conv_core_if;
  import conv_pkg::*;
  logic                     in_valid;
  logic [MAT_N*PIX_W-1:0]   in_row;
  logic [TAPS*PIX_W-1:0]    in_kernel;
  logic                     fifo_full;
  logic                     out_valid;
  logic [OUT_W-1:0]         out_data;
  logic                     busy;

  modport master (
    output in_valid, in_row, in_kernel, fifo_full,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_row, in_kernel, fifo_full,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/conv_mac4.sv
// Combinational 2x2 window dot product: four unsigned PIX_W x PIX_W products summed into OUT_W.
module conv_mac4
  import conv_pkg::*;
(
  input  logic [TAPS*PIX_W-1:0] pix_i,
  input  logic [TAPS*PIX_W-1:0] ker_i,
  output logic [OUT_W-1:0]      sum_o
);

  logic [2*PIX_W-1:0] prod [TAPS];

  always_comb begin
    for (int j = 0; j < TAPS; j++) begin
      prod[j] = (2*PIX_W)'(pix_i[j*PIX_W +: PIX_W]) * (2*PIX_W)'(ker_i[j*PIX_W +: PIX_W]);
    end
    sum_o = (OUT_W'(prod[0]) + OUT_W'(prod[1])) + (OUT_W'(prod[2]) + OUT_W'(prod[3]));
  end

endmodule

// File: rtl/conv_core.sv
// conv_core: loads a 6x6 image and six 2x2 kernels, then streams 150 results into the output FIFO.
// Optional build macro CONV_CORE_PROTO_CHK_EN adds a sticky proto_err output.
//
// state   | meaning
// ST_LOAD | accept in_valid beats, store image row n and kernel n
// ST_CALC | issue one result per cycle when the FIFO is not full
module conv_core
  import conv_pkg::*;
(
  input  logic        clk2,
  input  logic        rst_n,
  conv_core_if.slave  bus
`ifdef CONV_CORE_PROTO_CHK_EN
  ,
  output logic        proto_err
`endif
);

  logic [PIX_W-1:0]      img_q [MAT_N][MAT_N];
  logic [TAPS*PIX_W-1:0] ker_q [MAT_N];

  state_e                state_q;
  logic [CNT_W-1:0]      beat_q;
  logic [CNT_W-1:0]      k_q;
  logic [CNT_W-1:0]      r_q;
  logic [CNT_W-1:0]      c_q;
  logic                  out_valid_q;
  logic [OUT_W-1:0]      out_data_q;
  logic                  busy_q;

  logic                  load_beat;
  logic [CNT_W-1:0]      r1;
  logic [CNT_W-1:0]      c1;
  logic [TAPS*PIX_W-1:0] win_pix;
  logic [OUT_W-1:0]      mac_sum;

  assign load_beat = (state_q == ST_LOAD) && bus.in_valid;
  assign r1        = r_q + CNT_W'(1);
  assign c1        = c_q + CNT_W'(1);
  // Window taps packed in kernel element order: TL, TR, BL, BR.
  assign win_pix   = {img_q[r1][c1], img_q[r1][c_q], img_q[r_q][c1], img_q[r_q][c_q]};

  conv_mac4 u_mac4 (
    .pix_i (win_pix),
    .ker_i (ker_q[k_q]),
    .sum_o (mac_sum)
  );

  always_ff @(posedge clk2) begin
    if (load_beat) begin
      for (int c = 0; c < MAT_N; c++) begin
        img_q[beat_q][c] <= bus.in_row[c*PIX_W +: PIX_W];
      end
      ker_q[beat_q] <= bus.in_kernel;
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      beat_q      <= '0;
      k_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          if (bus.in_valid) begin
            busy_q <= 1'b1;
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              k_q     <= '0;
              r_q     <= '0;
              c_q     <= '0;
              state_q <= ST_CALC;
            end else begin
              beat_q <= beat_q + CNT_W'(1);
            end
          end
        end
        ST_CALC: begin
          if (!bus.fifo_full) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mac_sum;
            if (c_q == LAST_RC) begin
              c_q <= '0;
              if (r_q == LAST_RC) begin
                r_q <= '0;
                if (k_q == LAST_K) begin
                  // Final issue: busy falls together with the last out_valid.
                  k_q     <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ST_LOAD;
                end else begin
                  k_q <= k_q + CNT_W'(1);
                end
              end else begin
                r_q <= r_q + CNT_W'(1);
              end
            end else begin
              c_q <= c_q + CNT_W'(1);
            end
          end else begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

`ifdef CONV_CORE_PROTO_CHK_EN
  logic proto_err_q;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if ((state_q == ST_CALC) && bus.in_valid) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: doc/conv_core.md
Name: conv_core

Overview:
- Convolution engine in the clk2 domain.
- Receives the 6x6 image and six 2x2 kernels beat-by-beat from the clk1-to-clk2 handshake synchronizer.
- Computes all 150 valid-mode 2x2 convolution results.
- Writes them in order into the clk2-to-clk1 output FIFO, honouring FIFO backpressure.

Parameters:
- PIX_W, 3, bits per pixel and per kernel element (unsigned).
- MAT_N, 6, image side length; also number of kernels and number of input beats.
- OUT_W, 8, result width; must be >= 2*PIX_W+2 (no overflow possible, no saturation logic).

Ports:
- clk2  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  one-cycle strobe per beat from synchronizer; gaps between beats allowed.
- in_row  in  MAT_N*PIX_W (18)  image row; pixel c = in_row[3c+2:3c].
- in_kernel  in  4*PIX_W (12)  kernel; element j = in_kernel[3j+2:3j]; j0=TL, j1=TR, j2=BL, j3=BR.
- fifo_full  in  1  output FIFO cannot accept a write next cycle (FIFO raises it with >=1 entry margin).
- out_valid  out  1  FIFO write enable.
- out_data  out  OUT_W  result word; 0 when out_valid low.
- busy  out  1  high from first accepted beat until last result issued.

Behaviour:
- Reset: out_valid=0, out_data=0, busy=0; beat counter, result counters and FSM cleared; image/kernel storage need not be cleared.
- Reset is honoured mid-operation: any partial load or calculation is abandoned; no further writes after rst_n falls.
- FSM states: LOAD, CALC.
- LOAD:
  - Each in_valid beat n (0..5) stores in_row as image row n and in_kernel as kernel n; beat counter increments.
  - On the 6th beat, go to CALC next cycle; kernel k, row r and column c counters are zeroed.
- CALC:
  - Result index = k*25 + r*5 + c, issued in ascending order.
  - value = img[r][c]*K[k][0] + img[r][c+1]*K[k][1] + img[r+1][c]*K[k][2] + img[r+1][c+1]*K[k][3], zero-extended to OUT_W.
  - In a cycle where fifo_full=0: compute the current index and register it. out_valid=1 and out_data=value appear the next cycle. Counters advance: c wraps 4->0 with r++, r wraps 4->0 with k++.
  - In a cycle where fifo_full=1: no issue; counters hold; out_valid=0 and out_data=0 next cycle.
  - Latency: first write 2 cycles after the 6th beat if the FIFO is not full. Throughput is 1 result/cycle. 150 writes total per pattern.
  - After issuing index 149, return to LOAD; busy drops the cycle the last out_valid is high.
- in_valid during CALC is a protocol violation: the beat is ignored and storage is unchanged.
- in_valid in the same cycle as the final issue is also ignored.
- Back-to-back patterns: a new LOAD may begin the cycle after busy drops.

Optional Feature:
- Macro CONV_CORE_PROTO_CHK_EN.
- Defined: an extra output port proto_err (1 bit, reset 0). It is set sticky on any in_valid while in CALC, and cleared only by reset.
- Undefined: port and logic are absent; violating beats are silently ignored as above.

Decomposition:
- Shared package conv_pkg: PIX_W, MAT_N, KER_SZ=2, OUT_W, RES_PER_KER=(MAT_N-1)^2=25, RES_TOTAL=150; state enum for the FSM.
- One natural sub-module, conv_mac4: a combinational 4-product adder tree (four PIX_W x PIX_W multipliers plus sum), instantiated once in conv_core.

Test Plan:
- All pixels 1 (in_row=18'h09249) and all kernels 1 (in_kernel=12'h249), 6 contiguous beats -> 150 writes, every out_data=4, first write 2 cycles after beat 6.
- All pixels 7 (18'h3FFFF) and all kernels 7 (12'hFFF) -> every out_data=196; checks no width overflow.
- Row n pixel c = (n+c)%8 with kernel k = {k,0,0,1}, i.e. TL=1, BR=k; beats gapped by 3-7 idle cycles -> out_data matches the golden model index-by-index.
- Random data with fifo_full toggled pseudo-randomly (including held high 20 cycles) -> no out_valid in the cycle after fifo_full=1, order preserved, exactly 150 writes, out_data=0 whenever out_valid=0.
- rst_n pulsed low at result index 60 -> out_valid/out_data/busy go 0 immediately; a following full pattern produces a correct 150-result stream.
- With CONV_CORE_PROTO_CHK_EN: in_valid pulsed during CALC with row 18'h3FFFF -> proto_err=1 and stays 1; results still match the original image.
